// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
//
// Purpose
//   Sequences a two-road intersection through GREEN_A -> RED_AB -> GREEN_B ->
//   RED_BA from a one-second tick. Each road's green time adapts to the queue
//   on the opposing road and is held inside per-road bounds. Those bounds drop
//   by RUSH_OFS while rush hour is flagged.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   tick       in   one-cycle 1 Hz enable
//   hold       in   freeze; ticks arriving while hold=1 are discarded
//   rush       in   rush-hour flag (level)
//   carsA      in   [4:0] cars queued on road A (unsigned, saturating at 31)
//   carsB      in   [4:0] cars queued on road B (unsigned, saturating at 31)
//   greenA     out  road A lamp green (registered)
//   greenB     out  road B lamp green (registered)
//   phase      out  [1:0] FSM state: 0 GREEN_A, 1 RED_AB, 2 GREEN_B, 3 RED_BA
//   remaining  out  [6:0] seconds left in the current phase
//   phaseDone  out  one-cycle pulse following every phase change
//
// Handshake
//   There is no valid/ready pair. The only qualifier is the active tick
//   (tick=1 and hold=0). Every output changes only on the clk edge that
//   samples an active tick, except phaseDone, which drops back to 0 on the
//   edge after it was raised.
// -----------------------------------------------------------------------------
module intersection_phase_scheduler #(
  parameter int INIT_A   = 40,
  parameter int INIT_B   = 50,
  parameter int MIN_A    = 40,
  parameter int MAX_A    = 70,
  parameter int MIN_B    = 50,
  parameter int MAX_B    = 80,
  parameter int RUSH_OFS = 10,
  parameter int STEP     = 5,
  parameter int ALLRED   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       hold,
  input  logic       rush,
  input  logic [4:0] carsA,
  input  logic [4:0] carsB,
  output logic       greenA,
  output logic       greenB,
  output logic [1:0] phase,
  output logic [6:0] remaining,
  output logic       phaseDone
);

  typedef enum logic [1:0] {
    GREEN_A = 2'd0,
    RED_AB  = 2'd1,
    GREEN_B = 2'd2,
    RED_BA  = 2'd3
  } phase_t;

  localparam logic [7:0] MIN_A8   = 8'(MIN_A);
  localparam logic [7:0] MAX_A8   = 8'(MAX_A);
  localparam logic [7:0] MIN_B8   = 8'(MIN_B);
  localparam logic [7:0] MAX_B8   = 8'(MAX_B);
  localparam logic [7:0] RUSH8    = 8'(RUSH_OFS);
  localparam logic [7:0] STEP8    = 8'(STEP);
  localparam logic [6:0] ALLRED7  = 7'(ALLRED);
  localparam logic [6:0] INIT_A7  = 7'(INIT_A);
  localparam logic [6:0] INIT_B7  = 7'(INIT_B);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  phase_t     state;
  logic [6:0] durA;
  logic [6:0] durB;

  assign phase = state;

  // ---------------------------------------------------------------------------
  // Effective bounds. These follow rush combinationally, so a rush edge that
  // lands on the same tick as a phase end already shapes the clamp.
  // ---------------------------------------------------------------------------
  logic [7:0] rushOfs;
  logic [7:0] loA;
  logic [7:0] hiA;
  logic [7:0] loB;
  logic [7:0] hiB;

  assign rushOfs = rush ? RUSH8 : 8'd0;
  assign loA     = MIN_A8 - rushOfs;
  assign hiA     = MAX_A8 - rushOfs;
  assign loB     = MIN_B8 - rushOfs;
  assign hiB     = MAX_B8 - rushOfs;

  // Clamp an 8-bit intermediate into [lo, hi]. The bounds never exceed 127,
  // so the 7-bit result is lossless.
  function automatic logic [6:0] clampDur(input logic [7:0] val,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    logic [7:0] res;
    if (val < lo) begin
      res = lo;
    end else if (val > hi) begin
      res = hi;
    end else begin
      res = val;
    end
    clampDur = res[6:0];
  endfunction

  // Queue-driven adaptation of a green duration. The arithmetic is done
  // 8 bits wide so that 127+STEP cannot wrap before the clamp. A subtraction
  // that would go below zero floors at 0; the clamp then lifts it back to lo.
  function automatic logic [7:0] adaptDur(input logic [6:0] dur,
                                          input logic [4:0] cars);
    logic [7:0] wide;
    wide = {1'b0, dur};
    if (cars <= 5'd10) begin
      adaptDur = wide + STEP8;
    end else if (cars >= 5'd20) begin
      adaptDur = (wide > STEP8) ? (wide - STEP8) : 8'd0;
    end else begin
      adaptDur = wide;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Next-value helpers
  // ---------------------------------------------------------------------------
  logic       activeTick;
  logic       lastSec;
  logic       truncA;
  logic       truncB;
  logic [6:0] nextDurA;
  logic [6:0] nextDurB;
  logic [6:0] entryA;
  logic [6:0] entryB;
  logic [6:0] remDec;

  assign activeTick = tick & ~hold;
  // <=1 rather than ==1 so that a zero count can never stall the FSM.
  assign lastSec    = (remaining <= 7'd1);
  assign remDec     = remaining - 7'd1;

  // Rush truncation: a green longer than the current hi jumps straight to hi.
  assign truncA     = rush && ({1'b0, remaining} > hiA);
  assign truncB     = rush && ({1'b0, remaining} > hiB);

  // Road A's duration is driven by the queue waiting on road B, and vice versa.
  assign nextDurA   = clampDur(adaptDur(durA, carsB), loA, hiA);
  assign nextDurB   = clampDur(adaptDur(durB, carsA), loB, hiB);

  // A green always starts from the stored duration re-clamped to the bounds
  // in force at the moment of entry.
  assign entryA     = clampDur({1'b0, durA}, loA, hiA);
  assign entryB     = clampDur({1'b0, durB}, loB, hiB);

  // ---------------------------------------------------------------------------
  // Phase FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= GREEN_A;
      remaining <= INIT_A7;
      durA      <= INIT_A7;
      durB      <= INIT_B7;
      greenA    <= 1'b1;
      greenB    <= 1'b0;
      phaseDone <= 1'b0;
    end else begin
      phaseDone <= 1'b0;
      if (activeTick) begin
        unique case (state)
          GREEN_A: begin
            if (lastSec) begin
              state     <= RED_AB;
              remaining <= ALLRED7;
              durA      <= nextDurA;
              greenA    <= 1'b0;
              greenB    <= 1'b0;
              phaseDone <= 1'b1;
            end else if (truncA) begin
              remaining <= hiA[6:0];
            end else begin
              remaining <= remDec;
            end
          end

          RED_AB: begin
            if (lastSec) begin
              state     <= GREEN_B;
              remaining <= entryB;
              greenA    <= 1'b0;
              greenB    <= 1'b1;
              phaseDone <= 1'b1;
            end else begin
              remaining <= remDec;
            end
          end

          GREEN_B: begin
            if (lastSec) begin
              state     <= RED_BA;
              remaining <= ALLRED7;
              durB      <= nextDurB;
              greenA    <= 1'b0;
              greenB    <= 1'b0;
              phaseDone <= 1'b1;
            end else if (truncB) begin
              remaining <= hiB[6:0];
            end else begin
              remaining <= remDec;
            end
          end

          RED_BA: begin
            if (lastSec) begin
              state     <= GREEN_A;
              remaining <= entryA;
              greenA    <= 1'b1;
              greenB    <= 1'b0;
              phaseDone <= 1'b1;
            end else begin
              remaining <= remDec;
            end
          end

          default: begin
            state     <= GREEN_A;
            remaining <= INIT_A7;
            greenA    <= 1'b1;
            greenB    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_scheduler
//
// Directed bench for intersection_phase_scheduler. Driver tasks issue ticks and
// push the hand-computed response for each tick into exp_q; a monitor pops
// and compares on the falling edge after every sampled tick. Reset and
// between-tick values are checked directly.
//
// Expected vector layout: {phase[1:0], remaining[6:0], greenA, greenB, phaseDone}
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

  localparam int W = 12;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       hold;
  logic       rush;
  logic [4:0] carsA;
  logic [4:0] carsB;
  logic       greenA;
  logic       greenB;
  logic [1:0] phase;
  logic [6:0] remaining;
  logic       phaseDone;

  always #5 clk = ~clk;

  intersection_phase_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .hold      (hold),
    .rush      (rush),
    .carsA     (carsA),
    .carsB     (carsB),
    .greenA    (greenA),
    .greenB    (greenB),
    .phase     (phase),
    .remaining (remaining),
    .phaseDone (phaseDone)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           mon_idx = 0;
  logic         tick_d = 1'b0;

  function automatic logic [W-1:0] pack_exp(input logic [1:0] ph,
                                            input logic [6:0] rem,
                                            input logic       done);
    pack_exp = {ph, rem, (ph == 2'd0), (ph == 2'd2), done};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    dut_vec = {phase, remaining, greenA, greenB, phaseDone};
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] act,
                           input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got phase=%0d rem=%0d gA=%0b gB=%0b done=%0b, want phase=%0d rem=%0d gA=%0b gB=%0b done=%0b",
               name, act[11:10], act[9:3], act[2], act[1], act[0],
               exp[11:10], exp[9:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every tick sampled at a rising edge produces one response,
  // compared half a cycle later.
  // ---------------------------------------------------------------------------
  always @(posedge clk) tick_d <= tick;

  always @(negedge clk) begin
    if (tick_d === 1'b1) begin
      mon_idx++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tick%0d: response with no expected entry", mon_idx);
      end else begin
        check_vec($sformatf("tick%0d", mon_idx), dut_vec(), exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_tick(input logic [1:0] ph, input logic [6:0] rem,
                         input logic done);
    @(negedge clk);
    exp_q.push_back(pack_exp(ph, rem, done));
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Runs a phase that starts with 'len' seconds: len-1 plain decrements,
  // then the ending tick lands in phase nph with nrem seconds.
  task automatic run_phase(input logic [1:0] ph, input int len,
                           input logic [1:0] nph, input logic [6:0] nrem);
    for (int i = 1; i < len; i++) do_tick(ph, 7'(len - i), 1'b0);
    do_tick(nph, nrem, 1'b1);
  endtask

  task automatic idle_check(input string name, input logic [1:0] ph,
                            input logic [6:0] rem);
    @(negedge clk);
    check_vec(name, dut_vec(), pack_exp(ph, rem, 1'b0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    hold  = 1'b0;
    rush  = 1'b0;
    carsA = 5'd0;
    carsB = 5'd0;

    // Reset values, during and just after reset.
    repeat (2) @(negedge clk);
    check_vec("reset_hold", dut_vec(), pack_exp(2'd0, 7'd40, 1'b0));
    rst_n = 1'b1;
    idle_check("reset_release", 2'd0, 7'd40);

    // First cycle with an empty B queue: A green of 40, durA -> 45.
    run_phase(2'd0, 40, 2'd1, 7'd1);
    idle_check("done_clears", 2'd1, 7'd1);
    run_phase(2'd1, 1, 2'd2, 7'd50);
    do_tick(2'd2, 7'd49, 1'b0);
    do_tick(2'd2, 7'd48, 1'b0);

    // Asynchronous reset in the middle of GREEN_B, between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_vec("async_reset", dut_vec(), pack_exp(2'd0, 7'd40, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Long queues on both roads: durations shrink to, and stay at, the minimum.
    carsA = 5'd25;
    carsB = 5'd31;
    for (int c = 0; c < 6; c++) begin
      run_phase(2'd0, 40, 2'd1, 7'd1);
      run_phase(2'd1, 1, 2'd2, 7'd50);
      run_phase(2'd2, 50, 2'd3, 7'd1);
      run_phase(2'd3, 1, 2'd0, 7'd40);
    end

    // Short queues: both durations grow by 5 per cycle.
    carsA = 5'd5;
    carsB = 5'd10;
    for (int k = 0; k < 5; k++) begin
      run_phase(2'd0, 40 + 5 * k, 2'd1, 7'd1);
      run_phase(2'd1, 1, 2'd2, 7'(50 + 5 * k));
      run_phase(2'd2, 50 + 5 * k, 2'd3, 7'd1);
      run_phase(2'd3, 1, 2'd0, 7'(45 + 5 * k));
    end
    run_phase(2'd0, 65, 2'd1, 7'd1);      // durA -> 70
    run_phase(2'd1, 1, 2'd2, 7'd75);

    // Rush truncation: 75 > hi(70), next tick loads 70.
    rush = 1'b1;
    do_tick(2'd2, 7'd70, 1'b0);
    rush = 1'b0;
    run_phase(2'd2, 70, 2'd3, 7'd1);      // durB -> 80

    // Rush rises on the tick ending RED_BA: durA 70 clamps to 60.
    rush = 1'b1;
    run_phase(2'd3, 1, 2'd0, 7'd60);
    idle_check("simul_done_clears", 2'd0, 7'd60);

    // Hold during GREEN_A at 12: twenty lost ticks, then normal countdown.
    for (int i = 1; i <= 48; i++) do_tick(2'd0, 7'(60 - i), 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 20; i++) do_tick(2'd0, 7'd12, 1'b0);
    hold = 1'b0;
    run_phase(2'd0, 12, 2'd1, 7'd1);      // durA: 75 clamps to rush hi 60
    run_phase(2'd1, 1, 2'd2, 7'd70);      // durB 80 clamps to rush hi 70

    // Rush off again: durB saturates at 80, durA 60 re-enters unchanged.
    rush = 1'b0;
    run_phase(2'd2, 70, 2'd3, 7'd1);
    run_phase(2'd3, 1, 2'd0, 7'd60);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never seen, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
